// File: rtl/rf_dbg_reader.sv
// rf_dbg_reader: walks the register-file debug read port and streams
// register values out over a valid/ready interface, either as a full
// x0..x31 dump or as a single selected register.
module rf_dbg_reader (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        single_i,
  input  logic [4:0]  sel_i,
  input  logic        abort_i,
  output logic [4:0]  rR_o,
  input  logic [31:0] rD_i,
  output logic [31:0] data_o,
  output logic [4:0]  idx_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [4:0]  last_q;
  logic [31:0] data_q;
  logic [4:0]  idx_q;
  logic        valid_q;
  logic        done_q;

  // Next-value terms shared by the FSM below.
  logic [31:0] data_d;
  logic        hs_d;
  logic        last_beat_d;

  // x0 is hardwired zero regardless of what the read port returns;
  // a beat is consumed when the presented value is accepted.
  always_comb begin
    data_d      = (cnt_q == 5'd0) ? 32'h0 : rD_i;
    hs_d        = valid_q && ready_i;
    last_beat_d = (cnt_q == last_q);
  end

  // Read-port address is only driven while fetching; zero otherwise.
  assign rR_o    = (state_q == S_FETCH) ? cnt_q : 5'd0;
  assign busy_o  = (state_q != S_IDLE);
  assign data_o  = data_q;
  assign idx_o   = idx_q;
  assign valid_o = valid_q;
  assign done_o  = done_q;

  // Control FSM with registered beat and completion outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      last_q  <= 5'd0;
      data_q  <= 32'h0;
      idx_q   <= 5'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A full dump wins over a single read when both are requested.
          if (start_i) begin
            cnt_q   <= 5'd0;
            last_q  <= 5'd31;
            state_q <= S_FETCH;
          end else if (single_i) begin
            cnt_q   <= sel_i;
            last_q  <= sel_i;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (abort_i) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            data_q  <= data_d;
            idx_q   <= cnt_q;
            valid_q <= 1'b1;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          // Abort beats a coincident handshake; data holds until accepted.
          if (abort_i) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end else if (hs_d) begin
            valid_q <= 1'b0;
            if (last_beat_d) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              cnt_q   <= cnt_q + 5'd1;
              state_q <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rf_dbg_reader.md
RF_DBG_READER -- requirements
Module: rf_dbg_reader

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: reset is sampled only on the rising edge of clk_i.
REQ-002 clk_i  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  synchronous active-high reset.
REQ-004 start_i  input  1  request a full dump of x0..x31; sampled only in IDLE.
REQ-005 single_i  input  1  request a single-register read of sel_i; sampled only in IDLE.
REQ-006 sel_i  input  5  register index for single mode.
REQ-007 abort_i  input  1  cancel an in-progress dump.
REQ-008 rR_o  output  5  read address to the register-file debug read port.
REQ-009 rD_i  input  32  combinational read data from that port, valid in the same cycle as rR_o.
REQ-010 data_o  output  32  register value being presented.
REQ-011 idx_o  output  5  index of the register in data_o.
REQ-012 valid_o  output  1  data_o and idx_o are valid.
REQ-013 ready_i  input  1  consumer accepts the beat.
REQ-014 busy_o  output  1  high in every state except IDLE.
REQ-015 done_o  output  1  one-cycle pulse on completion.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, SEND and DONE, with a 5-bit current index cnt and a 5-bit final index last.
REQ-017 IDLE transitions:
- start_i=1: cnt<=0, last<=31, go to FETCH.
- else single_i=1: cnt<=sel_i, last<=sel_i, go to FETCH.
- start_i has priority when both requests are high.
REQ-018 FETCH SHALL drive rR_o=cnt and register the fetched value:
- data_o<=(cnt==0 ? 0 : rD_i), idx_o<=cnt, valid_o<=1.
- Go to SEND.
- Latency is 1 cycle from FETCH to valid_o high.
REQ-019 In SEND, valid_o SHALL stay high and data_o/idx_o SHALL stay stable until valid_o&&ready_i.
REQ-020 On a SEND handshake:
- valid_o<=0.
- If cnt==last, go to DONE.
- Else cnt<=cnt+1 and go to FETCH.
- cnt never wraps past 31, because last<=31.
REQ-021 DONE SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-022 Throughput SHALL be at most one register per 2 cycles with ready_i held high; a full dump takes 32 beats, 65 cycles from start_i to the done_o pulse.
REQ-023 abort_i in FETCH or SEND SHALL force IDLE on the next edge with valid_o<=0 and no done_o pulse; abort_i has priority over a simultaneous handshake. abort_i is ignored in IDLE and DONE.
REQ-024 start_i, single_i and sel_i SHALL be ignored while busy_o=1.
REQ-025 rR_o SHALL be 0 in IDLE, SEND and DONE, and cnt in FETCH.
REQ-026 rD_i SHALL be sampled only in FETCH; changes on rD_i while in SEND SHALL NOT alter data_o.

Reset
REQ-027 rst_i=1 SHALL force IDLE with cnt=0, last=0, data_o=0, idx_o=0, valid_o=0, busy_o=0, done_o=0 and rR_o=0.
REQ-028 Reset SHALL override all other inputs in any state, including mid-dump: no done_o pulse and no further beats after reset.
REQ-029 The first request SHALL be accepted in the first cycle after rst_i deasserts.

Verification
REQ-030 Full dump: rf loaded xN=0x1000_0000+N, start_i pulse, ready_i=1 -> 32 beats, idx 0..31, data 0, 0x1000_0001..0x1000_001F; done_o 65 cycles after start_i.
REQ-031 Single read: sel_i=7 with x7=0xDEADBEEF, single_i pulse -> one beat idx=7, data=0xDEADBEEF, then a done_o pulse, then busy_o=0.
REQ-032 Backpressure: ready_i=0 for 10 cycles on beat idx=3 -> valid_o held and data/idx stable for all 10 cycles; rD_i toggled meanwhile -> data_o unchanged; dump completes normally.
REQ-033 x0 forcing: rD_i forced to 0xFFFFFFFF at address 0, single_i with sel_i=0 -> data_o=0.
REQ-034 Abort and reset: abort_i during SEND of idx=5 -> IDLE next cycle, no done_o, start_i accepted afterwards; rst_i during FETCH of idx=20 -> all outputs 0, no further beats.
REQ-035 Simultaneous requests: start_i=1 and single_i=1 with sel_i=9 in IDLE -> full dump from idx 0; start_i pulsed while busy_o=1 -> ignored.
